// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_serial_slice.sv
// One-bit combinational ALU slice; the controller feeds it one operand bit pair per cycle.
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic    at,
  input  logic    bt,
  input  logic    cin,
  input  alu_op_e ALUcontrol,
  output logic    r,
  output logic    cout,
  output logic    cin_out
);

  logic bx;

  // Subtraction reuses the adder on inverted B; the controller supplies the +1 as preset carry.
  always_comb begin
    bx      = (ALUcontrol == SUB) ? ~bt : bt;
    r       = 1'b0;
    cout    = 1'b0;
    cin_out = cin;
    case (ALUcontrol)
      ADD, SUB: begin
        r    = at ^ bx ^ cin;
        cout = (at & bx) | (cin & (at ^ bx));
      end
      AND:     r = at & bt;
      OR:      r = at | bt;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: captures operands on start, runs one slice bit per cycle
// LSB first, and publishes result and flags in a single DONE cycle.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ALUcontrol,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  alu_state_e       state;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             r;
  logic             cout;
  logic             cin_msb;
  logic [WIDTH-1:0] full;
  logic             arith;

  alu_serial_slice u_slice (
    .at        (a_q[cnt]),
    .bt        (b_q[cnt]),
    .cin       (carry),
    .ALUcontrol(op_q),
    .r         (r),
    .cout      (cout),
    .cin_out   (cin_msb)
  );

  // The final bit is merged straight from the slice so the result is ready in the DONE cycle.
  assign full  = {r, sr};
  assign arith = (op_q == ADD) || (op_q == SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= ADD;
      a_q    <= '0;
      b_q    <= '0;
      sr     <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      Z      <= 1'b0;
      N      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= alu_op_e'(ALUcontrol);
            cnt   <= '0;
            carry <= ALUcontrol[0];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= cout;
          sr    <= full[WIDTH-1:1];
          if (cnt == LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= full;
            Z      <= (full == '0);
            N      <= r;
            C      <= arith & cout;
            V      <= arith & (cout ^ cin_msb);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed vectors, random ops against an arithmetic model,
// and hand-written sequences for ignored start, back-to-back and mid-operation reset.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   ALUcontrol;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         Z, N, C, V;

  int vectors;
  int miscompares;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] res;
    logic [3:0]   flags;
  } vec_t;

  vec_t vecs[8];

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .ALUcontrol(ALUcontrol),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .Z         (Z),
    .N         (N),
    .C         (C),
    .V         (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model from the arithmetic definition of each operation; flags packed as {Z,N,C,V}.
  function automatic void modelOp(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op,
                                  output logic [W-1:0] res, output logic [3:0] fl);
    logic [W:0] s;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        s = {1'b0, x} + {1'b0, y};
        c = s[W];
        v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      end
      2'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        c = s[W];
        v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
      end
      2'd2:    s = {1'b0, x & y};
      default: s = {1'b0, x | y};
    endcase
    res = s[W-1:0];
    fl  = {(res == '0), res[W-1], c, v};
  endfunction

  // One full operation from start to the idle cycle after done, with inputs scrambled after accept.
  task automatic applyStimulus(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                               input logic [1:0] op, input logic [W-1:0] expRes, input logic [3:0] expFl);
    int cycles;
    int busyCnt;
    @(negedge clk);
    a = ta; b = tb_; ALUcontrol = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); ALUcontrol = 2'($urandom);
    cycles  = 1;
    busyCnt = 0;
    while (!done && cycles <= W + 5) begin
      if (busy) busyCnt++;
      @(negedge clk);
      cycles++;
    end
    if (busy) busyCnt++;
    checkOutput({name, " latency"}, cycles, W + 1);
    checkOutput({name, " result"}, 32'(result), 32'(expRes));
    checkOutput({name, " flags ZNCV"}, 32'({Z, N, C, V}), 32'(expFl));
    @(negedge clk);
    checkOutput({name, " busy cycles"}, busyCnt, W + 1);
    checkOutput({name, " idle busy/done"}, 32'({busy, done}), 32'd0);
    checkOutput({name, " result hold"}, 32'(result), 32'(expRes));
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic [1:0]   rop;
    logic [3:0]   ef;
    int cycles, doneCount, doneAt, doneAt2;
    logic [W-1:0] resAtDone, resAtDone2;

    vectors = 0;
    miscompares = 0;

    vecs[0] = '{8'd100, 8'd27,  2'd0, 8'd127, 4'b0000};
    vecs[1] = '{8'h7F,  8'h01,  2'd0, 8'h80,  4'b0101};
    vecs[2] = '{8'hFF,  8'h01,  2'd0, 8'h00,  4'b1010};
    vecs[3] = '{8'd5,   8'd5,   2'd1, 8'h00,  4'b1010};
    vecs[4] = '{8'd3,   8'd5,   2'd1, 8'hFE,  4'b0100};
    vecs[5] = '{8'h80,  8'h01,  2'd1, 8'h7F,  4'b0011};
    vecs[6] = '{8'hF0,  8'h0F,  2'd2, 8'h00,  4'b1000};
    vecs[7] = '{8'hF0,  8'h0F,  2'd3, 8'hFF,  4'b0100};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ALUcontrol = 2'd0;
    #12;
    checkOutput("reset outputs", 32'({busy, done, result, Z, N, C, V}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flags);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom);
      if (i % 10 == 0) rb = ra;
      modelOp(ra, rb, rop, er, ef);
      applyStimulus($sformatf("rand%0d", i), ra, rb, rop, er, ef);
    end

    // Second start with new operands during RUN must be ignored.
    @(negedge clk);
    a = 8'd100; b = 8'd27; ALUcontrol = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCount = 0; doneAt = 0; resAtDone = '0;
    for (int cyc = 1; cyc <= 2 * W + 6; cyc++) begin
      if (cyc == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; ALUcontrol = 2'd3; end
      if (cyc == 5) start = 1'b0;
      if (done) begin doneCount++; doneAt = cyc; resAtDone = result; end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("ignore done count", doneCount, 1);
    checkOutput("ignore done cycle", doneAt, W + 1);
    checkOutput("ignore result", 32'(resAtDone), 32'd127);
    checkOutput("ignore result hold", 32'(result), 32'd127);

    // Start held high: one done every W+2 cycles.
    @(negedge clk);
    a = 8'h80; b = 8'h01; ALUcontrol = 2'd1; start = 1'b1;
    @(negedge clk);
    cycles = 1; doneCount = 0; doneAt = 0; doneAt2 = 0; resAtDone = '0; resAtDone2 = '0;
    while (doneCount < 2 && cycles <= 3 * W + 10) begin
      if (done) begin
        doneCount++;
        if (doneCount == 1) begin doneAt = cycles; resAtDone = result; end
        else begin doneAt2 = cycles; resAtDone2 = result; start = 1'b0; end
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checkOutput("b2b done count", doneCount, 2);
    checkOutput("b2b first done", doneAt, W + 1);
    checkOutput("b2b spacing", doneAt2 - doneAt, W + 2);
    checkOutput("b2b results", 32'({resAtDone, resAtDone2}), 32'h7F7F);
    repeat (2) @(negedge clk);

    // Reset in the middle of an ADD aborts it without a done pulse.
    a = 8'h55; b = 8'h33; ALUcontrol = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset outputs", 32'({busy, done, result, Z, N, C, V}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      if (done || busy) doneCount++;
      @(negedge clk);
    end
    checkOutput("midreset no activity", doneCount, 0);
    applyStimulus("post reset", 8'h55, 8'h33, 2'd0, 8'h88, 4'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
